spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The module SHALL have these ports:
- clk, input, 1 bit: single system clock; all logic is on its rising edge.
- reset, input, 1 bit: asynchronous, active-low reset.
- SPI_SCK, input, 1 bit: SPI clock from the master; asynchronous to clk.
- SPI_SS, input, 1 bit: slave select, active low.
- SPI_MOSI, input, 1 bit: master-out data.
- SPI_MISO, output, 1 bit: slave-out data.
- wr_buffer_free, output, 1 bit: high when the transmit buffer can accept a word.
- wr_en, input, 1 bit: one-cycle strobe that writes wr_data into the transmit buffer.
- wr_data, input, 32 bits: word to transmit.
- rd_data_available, output, 1 bit: high when a received word is held in rd_data.
- rd_ack, input, 1 bit: one-cycle strobe that consumes the received word.
- rd_data, output, 32 bits: last complete received word.
- cnt, output, 3 bits: count of completed received words, modulo 8.

REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.

Function
REQ-003 SPI protocol:
- SPI mode 0 (CPOL=0, CPHA=0), 32-bit words, MSB first.
- MOSI is sampled on the SCK rising edge; MISO changes after the SCK falling edge.
REQ-004 SPI_SCK, SPI_SS and SPI_MOSI SHALL each pass through a 2-flop synchronizer into clk, followed by edge detection. clk SHALL be at least 4x the SCK frequency.
REQ-005 A 5-bit bit counter SHALL increment on each synchronized SCK rising edge while SS is low.
REQ-006 On the 32nd rising edge:
- The 32-bit receive shift value SHALL be copied to rd_data.
- rd_data_available SHALL be set.
- cnt SHALL increment, wrapping 7->0.
- The bit counter SHALL return to 0, so back-to-back words within one SS-low frame are supported.
REQ-007 rd_data_available SHALL go high within 4 clk cycles of the 32nd SCK rising edge at the pin.
REQ-008 rd_ack with rd_data_available=1 SHALL clear rd_data_available on the next clk edge. rd_ack with rd_data_available=0 SHALL be ignored.
REQ-009 If a new word completes in the same cycle as rd_ack, or while rd_data_available=1 (overrun), rd_data SHALL take the new word and rd_data_available SHALL be 1.
REQ-010 wr_en with wr_buffer_free=1 SHALL latch wr_data into the transmit buffer and clear wr_buffer_free on the next edge. wr_en with wr_buffer_free=0 SHALL be ignored and the buffer kept.
REQ-011 At each word start (synchronized SS falling edge, or the cycle after the 32nd rising edge while SS stays low), the transmit shift register SHALL be loaded:
- from the buffer if the buffer is full, and wr_buffer_free is then set;
- with 32'h00000000 otherwise.
REQ-012 SPI_MISO SHALL drive the transmit-shift MSB. The shift register SHALL shift left by one on each synchronized SCK falling edge while SS is low. SPI_MISO SHALL be 0 while SS is high.
REQ-013 SS rising mid-word SHALL discard the partial word:
- bit counter cleared;
- no rd_data update and no cnt change;
- an unsent loaded transmit word is lost (the buffer is not restored).
REQ-014 If wr_en and a word-start load occur in the same cycle, the load SHALL use the old buffer state and the new write SHALL be accepted only if the buffer was free before that cycle.

Reset
REQ-015 While reset=0:
- rd_data = 0, rd_data_available = 0, cnt = 0;
- wr_buffer_free = 1, SPI_MISO = 0;
- shift registers, bit counter and synchronizers cleared (SS synchronizer to 1).
REQ-016 Reset asserted mid-frame SHALL abort the frame. After release, the next word starts only on a fresh SS falling edge.

Verification
REQ-017 Write 32'hDEADBEEF via wr_en, then clock a 32-bit frame with MOSI = 32'h12345678 -> MISO shows DEADBEEF MSB-first; rd_data = 12345678; rd_data_available = 1; cnt = 1; wr_buffer_free = 1.
REQ-018 Frame with no prior write -> MISO = all zeros; received word correct.
REQ-019 Two words without rd_ack (A5A5A5A5, then 0F0F0F0F) -> rd_data = 0F0F0F0F, available = 1, cnt = 2. A following rd_ack clears available.
REQ-020 SS raised after 12 bits, then a full frame with MOSI = 0000FFFF -> rd_data = 0000FFFF, cnt incremented once.
REQ-021 wr_en of 11111111 then 22222222 before any frame -> transmitted word is 11111111.
REQ-022 Nine complete words -> cnt = 1. Reset pulse mid-frame -> all outputs return to their reset values.

Source files
------------

// File: rtl/spi_slave.sv
// SPI mode-0 slave with 32-bit words, a single-word transmit buffer and a
// receive holding register. Every SPI pin is resynchronised into clk.
module spi_slave (
  input  logic        clk,
  input  logic        reset,
  input  logic        SPI_SCK,
  input  logic        SPI_SS,
  input  logic        SPI_MOSI,
  output logic        SPI_MISO,
  output logic        wr_buffer_free,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic        rd_data_available,
  input  logic        rd_ack,
  output logic [31:0] rd_data,
  output logic [2:0]  cnt
);

  logic        sck_meta_r, sck_sync_r, sck_prev_r;
  logic        ss_meta_r, ss_sync_r, ss_prev_r;
  logic        mosi_meta_r, mosi_sync_r;
  logic [1:0]  settle_r;
  logic        armed_r;
  logic        frame_r, skip_r, word_done_r;
  logic [4:0]  bit_cnt_r;
  logic [31:0] rx_shift_r, tx_shift_r, tx_buf_r, rd_data_r;
  logic        buf_free_r, rd_avail_r, miso_r;
  logic [2:0]  cnt_r;

  logic        sck_rise_s, sck_fall_s, ss_fall_s, active_s;
  logic        start_frame_s, word_start_s, done_s;
  logic        frame_next_s, skip_next_s, free_next_s;
  logic [31:0] tx_next_s, buf_next_s;

  assign sck_rise_s    = sck_sync_r & ~sck_prev_r;
  assign sck_fall_s    = ~sck_sync_r & sck_prev_r;
  assign ss_fall_s     = ~ss_sync_r & ss_prev_r;
  assign active_s      = frame_r & ~ss_sync_r;
  // A frame may only open once SS has been seen high after reset.
  assign start_frame_s = ss_fall_s & armed_r & ~frame_r;
  assign word_start_s  = start_frame_s | (word_done_r & active_s);
  assign done_s        = active_s & sck_rise_s & (bit_cnt_r == 5'd31);

  // Next-state for frame, transmit shifter and transmit buffer.
  always_comb begin
    frame_next_s = frame_r;
    skip_next_s  = skip_r;
    tx_next_s    = tx_shift_r;
    buf_next_s   = tx_buf_r;
    free_next_s  = buf_free_r;

    if (ss_sync_r) begin
      frame_next_s = 1'b0;
    end else if (start_frame_s) begin
      frame_next_s = 1'b1;
    end else begin
      frame_next_s = frame_r;
    end

    // After a back-to-back reload, the SCK fall that follows the last bit
    // must not shift away the freshly loaded MSB.
    if (ss_sync_r) begin
      skip_next_s = 1'b0;
    end else if (word_start_s) begin
      skip_next_s = word_done_r;
    end else if (active_s && sck_fall_s) begin
      skip_next_s = 1'b0;
    end else begin
      skip_next_s = skip_r;
    end

    if (word_start_s) begin
      tx_next_s = buf_free_r ? 32'h0000_0000 : tx_buf_r;
    end else if (active_s && sck_fall_s && !skip_r) begin
      tx_next_s = {tx_shift_r[30:0], 1'b0};
    end else begin
      tx_next_s = tx_shift_r;
    end

    if (wr_en && buf_free_r) begin
      buf_next_s  = wr_data;
      free_next_s = 1'b0;
    end else if (word_start_s && !buf_free_r) begin
      buf_next_s  = tx_buf_r;
      free_next_s = 1'b1;
    end else begin
      buf_next_s  = tx_buf_r;
      free_next_s = buf_free_r;
    end
  end

  // Pin synchronisers, edge-detect history and post-reset arming.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_meta_r  <= 1'b0;
      sck_sync_r  <= 1'b0;
      sck_prev_r  <= 1'b0;
      ss_meta_r   <= 1'b1;
      ss_sync_r   <= 1'b1;
      ss_prev_r   <= 1'b1;
      mosi_meta_r <= 1'b0;
      mosi_sync_r <= 1'b0;
      settle_r    <= 2'b00;
      armed_r     <= 1'b0;
    end else begin
      sck_meta_r  <= SPI_SCK;
      sck_sync_r  <= sck_meta_r;
      sck_prev_r  <= sck_sync_r;
      ss_meta_r   <= SPI_SS;
      ss_sync_r   <= ss_meta_r;
      ss_prev_r   <= ss_sync_r;
      mosi_meta_r <= SPI_MOSI;
      mosi_sync_r <= mosi_meta_r;
      settle_r    <= {settle_r[0], 1'b1};
      armed_r     <= armed_r | (settle_r[1] & ss_sync_r);
    end
  end

  // Frame datapath, receive path and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_r     <= 1'b0;
      skip_r      <= 1'b0;
      word_done_r <= 1'b0;
      bit_cnt_r   <= 5'd0;
      rx_shift_r  <= 32'h0000_0000;
      tx_shift_r  <= 32'h0000_0000;
      tx_buf_r    <= 32'h0000_0000;
      buf_free_r  <= 1'b1;
      rd_data_r   <= 32'h0000_0000;
      rd_avail_r  <= 1'b0;
      cnt_r       <= 3'd0;
      miso_r      <= 1'b0;
    end else begin
      frame_r     <= frame_next_s;
      skip_r      <= skip_next_s;
      tx_shift_r  <= tx_next_s;
      tx_buf_r    <= buf_next_s;
      buf_free_r  <= free_next_s;
      word_done_r <= done_s;
      miso_r      <= frame_next_s ? tx_next_s[31] : 1'b0;

      if (!active_s) begin
        bit_cnt_r <= 5'd0;
      end else if (sck_rise_s) begin
        bit_cnt_r  <= bit_cnt_r + 5'd1;
        rx_shift_r <= {rx_shift_r[30:0], mosi_sync_r};
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end

      if (done_s) begin
        rd_data_r  <= {rx_shift_r[30:0], mosi_sync_r};
        rd_avail_r <= 1'b1;
        cnt_r      <= cnt_r + 3'd1;
      end else if (rd_ack) begin
        rd_avail_r <= 1'b0;
      end else begin
        rd_avail_r <= rd_avail_r;
      end
    end
  end

  assign SPI_MISO          = miso_r;
  assign wr_buffer_free    = buf_free_r;
  assign rd_data_available = rd_avail_r;
  assign rd_data           = rd_data_r;
  assign cnt               = cnt_r;

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: a bit-banged SPI master, a word-level
// reference model, and monitors for received words and MISO.
`timescale 1ns/1ps
module tb_spi_slave;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        SPI_SCK = 1'b0;
  logic        SPI_SS = 1'b1;
  logic        SPI_MOSI = 1'b0;
  logic        SPI_MISO;
  logic        wr_buffer_free;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = 32'h0;
  logic        rd_data_available;
  logic        rd_ack = 1'b0;
  logic [31:0] rd_data;
  logic [2:0]  cnt;

  spi_slave dut (
    .clk(clk), .reset(reset),
    .SPI_SCK(SPI_SCK), .SPI_SS(SPI_SS), .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO),
    .wr_buffer_free(wr_buffer_free), .wr_en(wr_en), .wr_data(wr_data),
    .rd_data_available(rd_data_available), .rd_ack(rd_ack),
    .rd_data(rd_data), .cnt(cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  cnt;
  } rx_exp_t;

  int          checks = 0;
  int          errors = 0;
  rx_exp_t     rx_q[$];
  logic [31:0] tx_q[$];
  logic [31:0] model_buf[$];   // transmit buffer: empty or one word
  int          model_cnt = 0;
  bit          miso_mon_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wr_word(input logic [31:0] d);
    @(negedge clk);
    wr_data = d;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
    if (model_buf.size() == 0) model_buf.push_back(d);
  endtask

  task automatic ack();
    @(negedge clk);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] w, input int nbits);
    for (int i = 31; i > 31 - nbits; i--) begin
      SPI_MOSI = w[i];
      #80 SPI_SCK = 1'b1;
      #80 SPI_SCK = 1'b0;
    end
  endtask

  // Word 0 of a frame carries the buffered word (or zero); later words send zero.
  task automatic frame(input int n, input logic [31:0] w0, input logic [31:0] w1,
                       input logic [31:0] w2, input logic [31:0] w3);
    logic [31:0] w [4];
    logic [31:0] first_tx;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    first_tx = (model_buf.size() != 0) ? model_buf.pop_front() : 32'h0;
    @(negedge clk);
    SPI_SS = 1'b0;
    #160;
    for (int k = 0; k < n; k++) begin
      tx_q.push_back((k == 0) ? first_tx : 32'h0);
      model_cnt = (model_cnt + 1) % 8;
      rx_q.push_back('{data: w[k], cnt: 3'(model_cnt)});
      send_bits(w[k], 32);
    end
    #160 SPI_SS = 1'b1;
    #200;
  endtask

  task automatic partial(input int nbits, input logic [31:0] w);
    if (model_buf.size() != 0) void'(model_buf.pop_front());
    @(negedge clk);
    SPI_SS = 1'b0;
    #160;
    send_bits(w, nbits);
    #160 SPI_SS = 1'b1;
    #200;
  endtask

  // Received-word monitor: every cnt step means a word was delivered.
  logic [2:0] last_cnt = 3'd0;
  rx_exp_t    rx_e;
  always @(negedge clk) begin
    if (!reset) begin
      last_cnt = cnt;
    end else if (cnt !== last_cnt) begin
      last_cnt = cnt;
      if (rx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected actual=%h required=none", rd_data);
      end else begin
        rx_e = rx_q.pop_front();
        check("rx_data", rd_data, rx_e.data);
        check("rx_cnt", {29'd0, cnt}, {29'd0, rx_e.cnt});
        check("rx_avail", {31'd0, rd_data_available}, 32'd1);
      end
    end
  end

  // MISO monitor: the master's view, sampled on SCK rising edges.
  logic [31:0] miso_w = 32'h0;
  int          miso_n = 0;
  always @(posedge SPI_SCK or posedge SPI_SS or negedge reset) begin
    if (SPI_SS || !reset) begin
      miso_n = 0;
    end else if (miso_mon_en) begin
      miso_w = {miso_w[30:0], SPI_MISO};
      miso_n++;
      if (miso_n == 32) begin
        miso_n = 0;
        if (tx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL miso_unexpected actual=%h required=none", miso_w);
        end else begin
          check("miso_word", miso_w, tx_q.pop_front());
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_data"}, rd_data, 32'h0);
    check({tag, "_avail"}, {31'd0, rd_data_available}, 32'd0);
    check({tag, "_cnt"}, {29'd0, cnt}, 32'd0);
    check({tag, "_free"}, {31'd0, wr_buffer_free}, 32'd1);
    check({tag, "_miso"}, {31'd0, SPI_MISO}, 32'd0);
  endtask

  int c0;

  initial begin
    #33;
    @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Buffered word goes out while a word comes in.
    wr_word(32'hDEADBEEF);
    check("free_after_write", {31'd0, wr_buffer_free}, 32'd0);
    frame(1, 32'h12345678, 32'h0, 32'h0, 32'h0);
    check("free_after_frame", {31'd0, wr_buffer_free}, 32'd1);
    check("avail_after_frame", {31'd0, rd_data_available}, 32'd1);
    check("cnt_first", {29'd0, cnt}, 32'd1);
    check("miso_idle", {31'd0, SPI_MISO}, 32'd0);
    ack();

    // No write: zeros go out.
    frame(1, 32'hCAFEF00D, 32'h0, 32'h0, 32'h0);
    ack();

    // Overrun across two words, then ack, then ack with nothing held.
    frame(2, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'h0, 32'h0);
    check("overrun_data", rd_data, 32'h0F0F0F0F);
    check("overrun_avail", {31'd0, rd_data_available}, 32'd1);
    check("overrun_cnt", {29'd0, cnt}, 32'd4);
    ack();
    check("ack_clears", {31'd0, rd_data_available}, 32'd0);
    ack();
    check("ack_ignored_avail", {31'd0, rd_data_available}, 32'd0);
    check("ack_ignored_data", rd_data, 32'h0F0F0F0F);

    // Aborted word after 12 bits, then a full word.
    partial(12, 32'hFFFF0000);
    check("abort_cnt", {29'd0, cnt}, 32'd4);
    frame(1, 32'h0000FFFF, 32'h0, 32'h0, 32'h0);
    check("after_abort_data", rd_data, 32'h0000FFFF);
    check("after_abort_cnt", {29'd0, cnt}, 32'd5);

    // Second write into a full buffer is ignored.
    wr_word(32'h11111111);
    wr_word(32'h22222222);
    check("full_buffer", {31'd0, wr_buffer_free}, 32'd0);
    frame(1, 32'h87654321, 32'h0, 32'h0, 32'h0);

    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(1, 0) == 1) wr_word($urandom);
      frame($urandom_range(3, 1), $urandom, $urandom, $urandom, $urandom);
      if ($urandom_range(1, 0) == 1) ack();
    end

    // Nine words advance cnt by one modulo 8.
    c0 = model_cnt;
    frame(4, $urandom, $urandom, $urandom, $urandom);
    frame(4, $urandom, $urandom, $urandom, $urandom);
    frame(1, $urandom, 32'h0, 32'h0, 32'h0);
    check("nine_words_cnt", {29'd0, cnt}, 32'((c0 + 1) % 8));

    // Reset mid-frame with a buffered word pending.
    wr_word(32'h55555555);
    @(negedge clk);
    SPI_SS = 1'b0;
    #160;
    send_bits(32'hABCDEF01, 12);
    @(negedge clk);
    reset = 1'b0;
    model_cnt = 0;
    model_buf.delete();
    repeat (3) @(negedge clk);
    check_reset_outputs("midreset");
    miso_mon_en = 1'b0;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    send_bits(32'hFFFFFFFF, 32);
    #160;
    check("stale_ss_avail", {31'd0, rd_data_available}, 32'd0);
    check("stale_ss_cnt", {29'd0, cnt}, 32'd0);
    check("stale_ss_miso", {31'd0, SPI_MISO}, 32'd0);
    SPI_SS = 1'b1;
    #200;
    miso_mon_en = 1'b1;
    frame(1, 32'h13579BDF, 32'h0, 32'h0, 32'h0);
    check("post_reset_cnt", {29'd0, cnt}, 32'd1);
    check("post_reset_data", rd_data, 32'h13579BDF);

    #500;
    check("rx_queue_drained", 32'(rx_q.size()), 32'd0);
    check("tx_queue_drained", 32'(tx_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
